// File: rtl/watch_set_ctrl.sv
// Watch front-end: 1 Hz prescaler, button sync/debounce, mode FSM and
// set-time pulse generation with press-and-hold auto-repeat.
module watch_set_ctrl #(
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic       Clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic       Clk_1sec,
    output logic       clock_enable,
    output logic [1:0] set_state,
    output logic       min_inc,
    output logic       min_dec,
    output logic       hour_inc,
    output logic       hour_dec
);

    localparam int unsigned PS_W     = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam int unsigned DB_W     = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        ST_TIME      = 2'd0,
        ST_SET_HOUR  = 2'd1,
        ST_SET_MIN   = 2'd2,
        ST_STOPWATCH = 2'd3
    } state_e;

    // Button bit order everywhere: [0] mode, [1] up, [2] down.
    logic [2:0]        sync1_q, sync1_d, sync2_q, sync2_d;
    logic [2:0]        deb_q, deb_d, deb_prev_q, deb_prev_d;
    logic [DB_W-1:0]   db_cnt_q [3];
    logic [DB_W-1:0]   db_cnt_d [3];
    logic              mode_press_q, mode_press_d;
    state_e            state_q, state_d;
    logic [HOLD_W-1:0] hold_cnt_q [2];
    logic [HOLD_W-1:0] hold_cnt_d [2];
    logic [1:0]        rep_q, rep_d;
    logic [PS_W-1:0]   ps_cnt_q, ps_cnt_d;
    logic              clk_1sec_q, clk_1sec_d;
    logic              clock_enable_q, clock_enable_d;
    logic              hour_inc_q, hour_inc_d, hour_dec_q, hour_dec_d;
    logic              min_inc_q, min_inc_d, min_dec_q, min_dec_d;

    logic [2:0]        press_c;
    logic [1:0]        fire_c;
    logic              in_set_c, both_c, freeze_c;

    always_comb begin
        sync1_d        = {btn_down, btn_up, btn_mode};
        sync2_d        = sync1_q;
        deb_d          = deb_q;
        deb_prev_d     = deb_q;
        state_d        = state_q;
        rep_d          = rep_q;
        fire_c         = 2'b00;
        hour_inc_d     = 1'b0;
        hour_dec_d     = 1'b0;
        min_inc_d      = 1'b0;
        min_dec_d      = 1'b0;
        for (int i = 0; i < 3; i++) db_cnt_d[i] = '0;
        for (int k = 0; k < 2; k++) hold_cnt_d[k] = hold_cnt_q[k];

        // A new level is accepted only after DEBOUNCE_CYCLES differing samples in a row.
        for (int i = 0; i < 3; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (db_cnt_q[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
                end
            end
        end

        press_c      = deb_q & ~deb_prev_q;
        mode_press_d = press_c[0];

        if (mode_press_q) begin
            case (state_q)
                ST_TIME:     state_d = ST_SET_HOUR;
                ST_SET_HOUR: state_d = ST_SET_MIN;
                ST_SET_MIN:  state_d = ST_STOPWATCH;
                default:     state_d = ST_TIME;
            endcase
        end

        in_set_c = (state_q == ST_SET_HOUR) || (state_q == ST_SET_MIN);
        both_c   = deb_q[1] & deb_q[2];

        // Hold counter k counts cycles since the last pulse of its button.
        for (int k = 0; k < 2; k++) begin
            if (!in_set_c || both_c || press_c[0] || !deb_q[k+1]) begin
                hold_cnt_d[k] = '0;
                rep_d[k]      = 1'b0;
            end else if (press_c[k+1]) begin
                fire_c[k]     = 1'b1;
                hold_cnt_d[k] = HOLD_W'(1);
                rep_d[k]      = 1'b0;
            end else if (hold_cnt_q[k] != '0) begin
                if (hold_cnt_q[k] == (rep_q[k] ? HOLD_W'(REPEAT_PERIOD) : HOLD_W'(REPEAT_DELAY))) begin
                    fire_c[k]     = 1'b1;
                    hold_cnt_d[k] = HOLD_W'(1);
                    rep_d[k]      = 1'b1;
                end else begin
                    hold_cnt_d[k] = hold_cnt_q[k] + HOLD_W'(1);
                end
            end
        end

        hour_inc_d = fire_c[0] && (state_q == ST_SET_HOUR);
        hour_dec_d = fire_c[1] && (state_q == ST_SET_HOUR);
        min_inc_d  = fire_c[0] && (state_q == ST_SET_MIN);
        min_dec_d  = fire_c[1] && (state_q == ST_SET_MIN);

        // Frozen while either side of the edge is a SET state, so the 1 Hz
        // output restarts high on the first edge after leaving it.
        freeze_c = in_set_c || (state_d == ST_SET_HOUR) || (state_d == ST_SET_MIN);
        if (freeze_c) begin
            ps_cnt_d   = '0;
            clk_1sec_d = 1'b0;
        end else begin
            ps_cnt_d   = (ps_cnt_q == PS_W'(CLK_HZ - 1)) ? '0 : ps_cnt_q + PS_W'(1);
            clk_1sec_d = (ps_cnt_q < PS_W'(CLK_HZ / 2));
        end

        clock_enable_d = (state_d != ST_STOPWATCH);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            sync1_q        <= '0;
            sync2_q        <= '0;
            deb_q          <= '0;
            deb_prev_q     <= '0;
            mode_press_q   <= 1'b0;
            state_q        <= ST_TIME;
            rep_q          <= '0;
            ps_cnt_q       <= '0;
            clk_1sec_q     <= 1'b0;
            clock_enable_q <= 1'b1;
            hour_inc_q     <= 1'b0;
            hour_dec_q     <= 1'b0;
            min_inc_q      <= 1'b0;
            min_dec_q      <= 1'b0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
            for (int k = 0; k < 2; k++) hold_cnt_q[k] <= '0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            deb_q          <= deb_d;
            deb_prev_q     <= deb_prev_d;
            mode_press_q   <= mode_press_d;
            state_q        <= state_d;
            rep_q          <= rep_d;
            ps_cnt_q       <= ps_cnt_d;
            clk_1sec_q     <= clk_1sec_d;
            clock_enable_q <= clock_enable_d;
            hour_inc_q     <= hour_inc_d;
            hour_dec_q     <= hour_dec_d;
            min_inc_q      <= min_inc_d;
            min_dec_q      <= min_dec_d;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
            for (int k = 0; k < 2; k++) hold_cnt_q[k] <= hold_cnt_d[k];
        end
    end

    assign Clk_1sec     = clk_1sec_q;
    assign clock_enable = clock_enable_q;
    assign set_state    = state_q;
    assign hour_inc     = hour_inc_q;
    assign hour_dec     = hour_dec_q;
    assign min_inc      = min_inc_q;
    assign min_dec      = min_dec_q;

endmodule

// File: tb/tb_watch_set_ctrl.sv
// Bench for watch_set_ctrl: directed test-plan steps, then random button
// activity, every cycle compared against an event-time reference model.
module tb_watch_set_ctrl;

    localparam int CLK_HZ = 8;
    localparam int DB     = 4;
    localparam int RD     = 16;
    localparam int RP     = 4;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_mode = 1'b0, btn_up = 1'b0, btn_down = 1'b0;
    logic       Clk_1sec, clock_enable, min_inc, min_dec, hour_inc, hour_dec;
    logic [1:0] set_state;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state (values as they stand after the latest edge).
    logic [2:0] m_s1, m_s2, m_deb, m_debp, m_ev;
    int         m_run [3];
    int         m_hstart [2];
    int         m_st;
    logic       m_clk;
    logic [3:0] m_pul;           // [0] hour_inc [1] hour_dec [2] min_inc [3] min_dec
    int         m_cyc = 0;
    int         m_rstart = 0;

    // Observed-activity counters for directed window checks.
    int   c_hinc, c_hdec, c_minc, c_mdec, c_high, c_rise;
    logic prev_c1 = 1'b0;

    watch_set_ctrl #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .Clk(Clk), .reset(reset), .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .Clk_1sec(Clk_1sec), .clock_enable(clock_enable), .set_state(set_state),
        .min_inc(min_inc), .min_dec(min_dec), .hour_inc(hour_inc), .hour_dec(hour_dec)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance the model by one rising edge using the inputs the DUT saw there.
    task automatic model_edge();
        logic [2:0] s2o, debo, debpo, evo, evd;
        int         sto, el;
        logic       setst, both, fire;
        if (reset) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_debp = '0; m_ev = '0;
            for (int b = 0; b < 3; b++) m_run[b] = 0;
            m_hstart[0] = -1; m_hstart[1] = -1;
            m_st = 0; m_clk = 1'b0; m_pul = '0;
            m_rstart = m_cyc + 1;
        end else begin
            s2o = m_s2; debo = m_deb; debpo = m_debp; evo = m_ev; sto = m_st;
            evd = debo & ~debpo;
            m_s2 = m_s1;
            m_s1 = {btn_down, btn_up, btn_mode};
            for (int b = 0; b < 3; b++) begin
                if (s2o[b] != debo[b]) m_run[b]++; else m_run[b] = 0;
                if (m_run[b] == DB) begin
                    m_deb[b] = s2o[b];
                    m_run[b] = 0;
                end
            end
            m_debp = debo;
            m_ev   = evd;
            if (evo[0]) m_st = (m_st + 1) % 4;
            m_pul = '0;
            setst = (sto == 1) || (sto == 2);
            both  = debo[1] & debo[2];
            for (int k = 0; k < 2; k++) begin
                fire = 1'b0;
                if (!setst || both || evd[0] || !debo[k+1]) begin
                    m_hstart[k] = -1;
                end else if (evd[k+1]) begin
                    fire = 1'b1;
                    m_hstart[k] = m_cyc;
                end else if (m_hstart[k] >= 0) begin
                    el = m_cyc - m_hstart[k];
                    if (el == RD || (el > RD && (el - RD) % RP == 0)) fire = 1'b1;
                end
                if (fire) m_pul[(sto == 1 ? 0 : 2) + k] = 1'b1;
            end
            if (setst || m_st == 1 || m_st == 2) begin
                m_clk = 1'b0;
                m_rstart = m_cyc + 1;
            end else begin
                m_clk = ((m_cyc - m_rstart) % CLK_HZ) < (CLK_HZ / 2);
            end
        end
        m_cyc++;
    endtask

    task automatic step();
        @(posedge Clk);
        model_edge();
        #1;
        chk("set_state", 32'(set_state), 32'(m_st));
        chk("clock_enable", 32'(clock_enable), 32'(m_st != 3));
        chk("Clk_1sec", 32'(Clk_1sec), 32'(m_clk));
        chk("hour_inc", 32'(hour_inc), 32'(m_pul[0]));
        chk("hour_dec", 32'(hour_dec), 32'(m_pul[1]));
        chk("min_inc", 32'(min_inc), 32'(m_pul[2]));
        chk("min_dec", 32'(min_dec), 32'(m_pul[3]));
        if (hour_inc) c_hinc++;
        if (hour_dec) c_hdec++;
        if (min_inc)  c_minc++;
        if (min_dec)  c_mdec++;
        if (Clk_1sec) c_high++;
        if (Clk_1sec && !prev_c1) c_rise++;
        prev_c1 = Clk_1sec;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr();
        c_hinc = 0; c_hdec = 0; c_minc = 0; c_mdec = 0; c_high = 0; c_rise = 0;
    endtask

    task automatic mode_press();
        btn_mode = 1'b1;
        steps(10);
        btn_mode = 1'b0;
        steps(12);
    endtask

    initial begin
        int cnt [3];
        int guard;
        clr();

        // Reset state
        steps(2);
        chk("rst_set_state", 32'(set_state), 32'd0);
        chk("rst_clk1sec", 32'(Clk_1sec), 32'd0);
        chk("rst_clock_enable", 32'(clock_enable), 32'd1);
        chk("rst_pulses", 32'({hour_inc, hour_dec, min_inc, min_dec}), 32'd0);

        // Free run: 8-cycle period, 4 high / 4 low
        reset = 1'b0;
        clr();
        steps(32);
        chk("run_high_cycles", 32'(c_high), 32'd16);
        chk("run_rises", 32'(c_rise), 32'd4);
        chk("run_pulses", 32'(c_hinc + c_hdec + c_minc + c_mdec), 32'd0);

        // Glitch ignored, then clean press
        btn_mode = 1'b1; steps(3);
        btn_mode = 1'b0; steps(10);
        chk("glitch_state", 32'(set_state), 32'd0);
        btn_mode = 1'b1; steps(7);
        chk("press_edge7", 32'(set_state), 32'd0);
        steps(1);
        chk("press_edge8", 32'(set_state), 32'd1);
        steps(2);
        btn_mode = 1'b0;
        clr();
        steps(12);
        chk("set_hour_clk_frozen", 32'(c_high), 32'd0);

        // SET_HOUR: hold up 40 cycles -> pulses at +0,+16,+20,...,+36
        clr();
        btn_up = 1'b1; steps(40);
        btn_up = 1'b0; steps(20);
        chk("hold_hour_inc", 32'(c_hinc), 32'd7);
        chk("hold_no_min", 32'(c_minc + c_mdec + c_hdec), 32'd0);

        // SET_MIN: one tap, then both held
        mode_press();
        chk("to_set_min", 32'(set_state), 32'd2);
        clr();
        btn_down = 1'b1; steps(6);
        btn_down = 1'b0; steps(15);
        chk("tap_min_dec", 32'(c_mdec), 32'd1);
        chk("tap_others", 32'(c_hinc + c_hdec + c_minc), 32'd0);
        clr();
        btn_up = 1'b1; btn_down = 1'b1; steps(30);
        btn_up = 1'b0; btn_down = 1'b0; steps(15);
        chk("both_no_pulses", 32'(c_hinc + c_hdec + c_minc + c_mdec), 32'd0);

        // Leave SET_MIN: Clk_1sec rises on the following edge
        btn_mode = 1'b1;
        guard = 0;
        while (set_state != 2'd3 && guard < 20) begin
            step();
            guard++;
        end
        chk("to_stopwatch", 32'(set_state), 32'd3);
        chk("sw_clock_enable", 32'(clock_enable), 32'd0);
        chk("clk_low_at_exit", 32'(Clk_1sec), 32'd0);
        step();
        chk("clk_rise_after_exit", 32'(Clk_1sec), 32'd1);
        steps(5);
        btn_mode = 1'b0; steps(12);
        mode_press();
        chk("wrap_time", 32'(set_state), 32'd0);
        chk("time_clock_enable", 32'(clock_enable), 32'd1);
        mode_press();
        chk("again_set_hour", 32'(set_state), 32'd1);

        // Reset mid-repeat discards everything
        btn_up = 1'b1; steps(25);
        reset = 1'b1; steps(1);
        chk("mid_rst_state", 32'(set_state), 32'd0);
        chk("mid_rst_pulses", 32'({hour_inc, hour_dec, min_inc, min_dec}), 32'd0);
        reset = 1'b0;
        clr();
        steps(40);
        chk("post_rst_no_hour_inc", 32'(c_hinc), 32'd0);
        btn_up = 1'b0; steps(15);

        // Random button activity with occasional resets
        for (int b = 0; b < 3; b++) cnt[b] = 0;
        for (int i = 0; i < 3000; i++) begin
            if (cnt[0] == 0) begin btn_mode = 1'($urandom_range(0, 1)); cnt[0] = $urandom_range(1, 30); end
            if (cnt[1] == 0) begin btn_up   = 1'($urandom_range(0, 1)); cnt[1] = $urandom_range(1, 45); end
            if (cnt[2] == 0) begin btn_down = 1'($urandom_range(0, 1)); cnt[2] = $urandom_range(1, 45); end
            for (int b = 0; b < 3; b++) cnt[b]--;
            reset = ($urandom_range(0, 399) == 0);
            step();
        end
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/watch_set_ctrl.md
Name: watch_set_ctrl

Overview:
- Front-end controller that drives the digital clock time counter.
- Generates the 1 Hz clock for the counter from the system clock.
- Debounces three raw push-buttons (mode, up, down) and runs the watch mode state machine.
- Emits single-cycle min_inc/min_dec/hour_inc/hour_dec pulses with press-and-hold auto-repeat, plus the clock_enable display-select level.

Parameters:
- CLK_HZ, 50000000, system clock cycles per second; even, >= 4.
- DEBOUNCE_CYCLES, 500000, consecutive stable synchronized samples required to accept a new button level; >= 2.
- REPEAT_DELAY, 25000000, cycles an up/down button must be held after its press pulse before the first repeat pulse.
- REPEAT_PERIOD, 5000000, cycles between successive repeat pulses; >= 2.

Ports:
- Clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- btn_mode  input  1  raw mode button, asynchronous, active-high.
- btn_up  input  1  raw up button, asynchronous, active-high.
- btn_down  input  1  raw down button, asynchronous, active-high.
- Clk_1sec  output  1  1 Hz square wave feeding the time counter.
- clock_enable  output  1  1 = current-time display, 0 = stopwatch display.
- set_state  output  2  0 TIME, 1 SET_HOUR, 2 SET_MIN, 3 STOPWATCH.
- min_inc  output  1  one-cycle pulse.
- min_dec  output  1  one-cycle pulse.
- hour_inc  output  1  one-cycle pulse.
- hour_dec  output  1  one-cycle pulse.

Behaviour:
- Reset (synchronous, sampled on Clk edge):
  - set_state=TIME, clock_enable=1, Clk_1sec=0.
  - All pulse outputs 0.
  - Synchronizers, debounced levels, debounce counters, prescaler and repeat counters all 0.
- Synchronizer: each button passes through a 2-flop synchronizer.
- Debounce (per button):
  - The counter increments each edge the synchronized value differs from the debounced level, and clears when they match.
  - When the counter is at DEBOUNCE_CYCLES-1 and the values still differ, the debounced level takes the new value and the counter clears.
  - A raw level first sampled at edge 1 updates the debounced level at edge DEBOUNCE_CYCLES+2.
  - Press event = registered debounced rising edge, high for the single cycle after edge DEBOUNCE_CYCLES+3.
- Mode FSM, advanced on each mode press event: TIME -> SET_HOUR -> SET_MIN -> STOPWATCH -> TIME.
  - clock_enable = 0 only in STOPWATCH.
  - set_state is registered and changes on the edge that consumes the press event.
- Up/down handling:
  - Ignored in TIME and STOPWATCH; no pulses are emitted there.
  - SET_HOUR: up press -> hour_inc, down press -> hour_dec.
  - SET_MIN: up press -> min_inc, down press -> min_dec.
  - Pulses are registered, exactly 1 cycle wide, and emitted in the same cycle the press event is high.
- Auto-repeat:
  - While the debounced up (or down) level stays high in a SET state, the hold counter runs from the press pulse.
  - First repeat pulse comes REPEAT_DELAY cycles after the press pulse, then one every REPEAT_PERIOD cycles.
  - Release or leaving the SET state clears the hold counter.
- Conflicts:
  - Up and down debounced high together: no pulses, and both hold counters clear.
  - A mode press event in the same cycle as an up/down pulse: mode wins, that pulse is suppressed, and hold counters clear.
  - A button already held when a SET state is entered generates nothing until it is released and pressed again.
- Prescaler:
  - Counter runs 0..CLK_HZ-1, wrapping.
  - Clk_1sec is registered: 1 while count < CLK_HZ/2, else 0.
  - In SET_HOUR and SET_MIN the count is held at 0 and Clk_1sec is forced to 0, freezing the seconds.
  - On return to STOPWATCH or TIME, counting resumes from 0, so Clk_1sec rises on the first edge after the state changes.
- Never emit more than one of the four pulse outputs in a cycle.
- Reset mid-debounce or mid-hold discards all partial state; no pulse in the cycle after reset.

Test Plan (CLK_HZ=8, DEBOUNCE_CYCLES=4, REPEAT_DELAY=16, REPEAT_PERIOD=4):
- Reset then free-run 32 cycles -> Clk_1sec period 8 cycles, high 4 / low 4, set_state=0, clock_enable=1, no pulses.
- Raw btn_mode glitch high 3 cycles, then a clean press held 10 cycles -> glitch ignored; set_state 0->1 exactly 8 cycles after the clean press first samples high; Clk_1sec stays 0 while in state 1.
- In SET_HOUR, btn_up held 40 cycles -> hour_inc pulses at press+0, +16, +20, +24, +28 … (each 1 cycle wide); no min_* pulses.
- In SET_MIN, tap btn_down once -> exactly one min_dec; then both up and down held 30 cycles -> zero pulses.
- Four mode presses -> set_state 1,2,3,0; clock_enable=0 only at 3; Clk_1sec rises on the first edge after leaving state 2.
- Assert reset while btn_up is held in SET_HOUR mid-repeat -> next cycle set_state=0 and no pulses; continued holding after reset produces no hour_inc.
